// File: rtl/antilog_pipe.sv
// Two-stage antilog pipeline: rebuilds a product from summed log characteristics
// and fractions, with saturation, optional sign, valid/ready flow control and counters.
module antilog_pipe #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned M_WIDTH   = 6,
  parameter int unsigned SIGNED_EN = 0,
  localparam int unsigned PW       = 2 * DWIDTH,
  localparam int unsigned KW       = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KW-1:0]     sum_k,
  input  logic [M_WIDTH:0]  sum_x,
  input  logic              in_zero,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     product,
  output logic              out_sat,
  input  logic              cnt_clr,
  output logic [15:0]       ops_cnt,
  output logic [15:0]       sat_cnt
);

  localparam int unsigned FKW = KW + 1;
  localparam int unsigned MNW = M_WIDTH + 1;

  logic           s1_valid_q;
  logic [FKW-1:0] s1_k_q;
  logic [MNW-1:0] s1_mant_q;
  logic           s1_zero_q;
  logic           s1_sign_q;
  logic           s2_valid_q;
  logic [PW-1:0]  s2_prod_q;
  logic           s2_sat_q;
  logic [15:0]    ops_q;
  logic [15:0]    satc_q;

  logic           adv1;
  logic           adv2;
  logic [FKW-1:0] s1_k_d;
  logic [MNW-1:0] s1_mant_d;
  logic [31:0]    k_ext;
  logic [PW-1:0]  mant_ext;
  logic [PW-1:0]  mag_d;
  logic           sat_d;
  logic [PW-1:0]  prod_d;

  // A stage may advance when it is empty or its consumer is taking data
  always_comb begin
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  always_comb begin
    s1_k_d    = FKW'(sum_k) + FKW'(sum_x[M_WIDTH]);
    s1_mant_d = {1'b1, sum_x[M_WIDTH-1:0]};
  end

  // Stage 2 datapath: align mantissa by final characteristic, saturate, apply sign
  always_comb begin
    k_ext    = 32'(s1_k_q);
    mant_ext = PW'(s1_mant_q);
    mag_d    = '0;
    sat_d    = 1'b0;
    if (!s1_zero_q) begin
      if (k_ext >= PW) begin
        mag_d = '1;
        sat_d = 1'b1;
      end else if (k_ext >= M_WIDTH) begin
        mag_d = mant_ext << (k_ext - M_WIDTH);
      end else begin
        mag_d = mant_ext >> (M_WIDTH - k_ext);
      end
    end
    prod_d = mag_d;
    if ((SIGNED_EN != 0) && s1_sign_q) begin
      prod_d = sat_d ? {1'b1, {(PW-1){1'b0}}} : (~mag_d + PW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_mant_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_k_q    <= s1_k_d;
        s1_mant_q <= s1_mant_d;
        s1_zero_q <= in_zero;
        s1_sign_q <= in_sign;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod_d;
        s2_sat_q  <= sat_d;
      end
    end
  end

  // Clear wins over a same-cycle increment; saturation counter sticks at max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q  <= '0;
      satc_q <= '0;
    end else if (cnt_clr) begin
      ops_q  <= '0;
      satc_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      ops_q <= ops_q + 16'd1;
      if (s2_sat_q && (satc_q != 16'hFFFF)) begin
        satc_q <= satc_q + 16'd1;
      end
    end
  end

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign product   = s2_prod_q;
  assign out_sat   = s2_sat_q;
  assign ops_cnt   = ops_q;
  assign sat_cnt   = satc_q;

endmodule

// File: tb/tb_antilog_pipe.sv
// Bench for antilog_pipe: unsigned and signed instances share stimulus; vector table,
// handshake corner sequences and random traffic checked through per-instance scoreboards.
module tb_antilog_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned MW = 6;
  localparam int unsigned PW = 32;
  localparam int unsigned KW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_zero, in_sign, out_ready, cnt_clr;
  logic [KW-1:0] sum_k;
  logic [MW:0]   sum_x;

  logic          in_ready_u, out_valid_u, out_sat_u;
  logic [PW-1:0] product_u;
  logic [15:0]   ops_u, satc_u;
  logic          in_ready_s, out_valid_s, out_sat_s;
  logic [PW-1:0] product_s;
  logic [15:0]   ops_s, satc_s;

  antilog_pipe #(.DWIDTH(DW), .M_WIDTH(MW), .SIGNED_EN(0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .sum_k(sum_k), .sum_x(sum_x), .in_zero(in_zero), .in_sign(in_sign),
    .out_valid(out_valid_u), .out_ready(out_ready), .product(product_u),
    .out_sat(out_sat_u), .cnt_clr(cnt_clr), .ops_cnt(ops_u), .sat_cnt(satc_u)
  );

  antilog_pipe #(.DWIDTH(DW), .M_WIDTH(MW), .SIGNED_EN(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .sum_k(sum_k), .sum_x(sum_x), .in_zero(in_zero), .in_sign(in_sign),
    .out_valid(out_valid_s), .out_ready(out_ready), .product(product_s),
    .out_sat(out_sat_s), .cnt_clr(cnt_clr), .ops_cnt(ops_s), .sat_cnt(satc_s)
  );

  typedef struct {
    logic [KW-1:0] k;
    logic [MW:0]   x;
    logic          z;
    logic          s;
    logic [PW-1:0] pu;
    logic          su;
    logic [PW-1:0] ps;
    logic          ss;
  } vec_t;

  typedef struct {
    logic [PW-1:0] p;
    logic          sat;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ops  = 0;
  int   exp_sat  = 0;
  vec_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: place the mantissa at bit final_k, then drop MW fraction bits
  function automatic logic [PW:0] model(input logic [KW-1:0] k, input logic [MW:0] x,
                                        input logic z, input logic s, input bit sen);
    longint unsigned fk, v;
    logic [PW-1:0] p;
    if (z) return '0;
    fk = 64'(k) + 64'(x[MW]);
    if (fk >= PW) return {1'b1, (sen && s) ? 32'h8000_0000 : 32'hFFFF_FFFF};
    v = ((64'd64 + 64'(x[MW-1:0])) << fk) >> MW;
    p = v[PW-1:0];
    if (sen && s) p = 32'd0 - p;
    return {1'b0, p};
  endfunction

  function automatic vec_t mkv(input logic [KW-1:0] k, input logic [MW:0] x,
                               input logic z, input logic s);
    vec_t r;
    logic [PW:0] m;
    r.k = k; r.x = x; r.z = z; r.s = s;
    m = model(k, x, z, s, 1'b0);
    r.pu = m[PW-1:0]; r.su = m[PW];
    m = model(k, x, z, s, 1'b1);
    r.ps = m[PW-1:0]; r.ss = m[PW];
    return r;
  endfunction

  // One cycle: settle, score handshakes seen this cycle, then cross the rising edge
  task automatic step(output logic acc);
    exp_t e;
    logic hs, hs_sat;
    #1;
    check("ops_cnt_u", 32'(ops_u), 32'(exp_ops));
    check("ops_cnt_s", 32'(ops_s), 32'(exp_ops));
    check("sat_cnt_u", 32'(satc_u), 32'(exp_sat));
    check("sat_cnt_s", 32'(satc_s), 32'(exp_sat));
    hs = 1'b0;
    hs_sat = 1'b0;
    if (out_valid_u && out_ready) begin
      hs = 1'b1;
      if (q_u.size() == 0) flag("unexpected_out_u");
      else begin
        e = q_u.pop_front();
        hs_sat = e.sat;
        check("product_u", product_u, e.p);
        check("out_sat_u", 32'(out_sat_u), 32'(e.sat));
      end
    end
    if (out_valid_s && out_ready) begin
      if (q_s.size() == 0) flag("unexpected_out_s");
      else begin
        e = q_s.pop_front();
        check("product_s", product_s, e.p);
        check("out_sat_s", 32'(out_sat_s), 32'(e.sat));
      end
    end
    if (cnt_clr) begin
      exp_ops = 0;
      exp_sat = 0;
    end else if (hs) begin
      exp_ops = (exp_ops + 1) % 65536;
      if (hs_sat && exp_sat < 65535) exp_sat++;
    end
    acc = in_valid && in_ready_u;
    if (acc) q_u.push_back('{cur.pu, cur.su});
    if (in_valid && in_ready_s) q_s.push_back('{cur.ps, cur.ss});
    @(posedge clk);
  endtask

  task automatic drive(input logic v, input vec_t d, input logic ordy, input logic clr,
                       output logic acc);
    @(negedge clk);
    in_valid  = v;
    sum_k     = d.k;
    sum_x     = d.x;
    in_zero   = d.z;
    in_sign   = d.s;
    out_ready = ordy;
    cnt_clr   = clr;
    cur       = d;
    step(acc);
  endtask

  task automatic send(input vec_t d, input logic ordy);
    logic acc;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, d, ordy, 1'b0, acc);
      if (acc) return;
    end
    flag("accept_timeout");
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    drive(1'b0, mkv('0, '0, 1'b0, 1'b0), ordy, clr, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q_u.size() != 0 || q_s.size() != 0); i++) idle(1'b1, 1'b0);
    check("drain_u", 32'(q_u.size()), 32'd0);
    check("drain_s", 32'(q_s.size()), 32'd0);
  endtask

  initial begin
    vec_t a, b, c;
    logic acc;
    tbl[0]  = '{5'd5,  7'b1000000, 1'b0, 1'b0, 32'd64,         1'b0, 32'd64,         1'b0};
    tbl[1]  = '{5'd3,  7'b0100000, 1'b0, 1'b1, 32'd12,         1'b0, 32'hFFFF_FFF4,  1'b0};
    tbl[2]  = '{5'd31, 7'b1000000, 1'b0, 1'b0, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1};
    tbl[3]  = '{5'd31, 7'b1000000, 1'b1, 1'b1, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[4]  = '{5'd31, 7'b1000000, 1'b0, 1'b1, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  1'b1};
    tbl[5]  = '{5'd0,  7'b0000000, 1'b0, 1'b0, 32'd1,          1'b0, 32'd1,          1'b0};
    tbl[6]  = '{5'd0,  7'b0000000, 1'b0, 1'b1, 32'd1,          1'b0, 32'hFFFF_FFFF,  1'b0};
    tbl[7]  = '{5'd25, 7'b0111111, 1'b0, 1'b0, 32'h03F8_0000,  1'b0, 32'h03F8_0000,  1'b0};
    tbl[8]  = '{5'd31, 7'b0000000, 1'b0, 1'b0, 32'h8000_0000,  1'b0, 32'h8000_0000,  1'b0};
    tbl[9]  = '{5'd30, 7'b1111111, 1'b0, 1'b1, 32'hFE00_0000,  1'b0, 32'h0200_0000,  1'b0};
    tbl[10] = '{5'd2,  7'b0000001, 1'b0, 1'b0, 32'd4,          1'b0, 32'd4,          1'b0};
    tbl[11] = '{5'd0,  7'b1000001, 1'b0, 1'b0, 32'd2,          1'b0, 32'd2,          1'b0};

    rst = 1'b1; in_valid = 1'b0; sum_k = '0; sum_x = '0; in_zero = 1'b0;
    in_sign = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_u), 32'd0);
    check("rst_in_ready", 32'(in_ready_u), 32'd1);
    check("rst_product", product_s, 32'd0);
    check("rst_ops", 32'(ops_u), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table vectors, then clear counters while the tail is emitting
    foreach (tbl[i]) send(tbl[i], 1'b1);
    idle(1'b1, 1'b1);
    drain();

    // Stall with A,B held and C refused, then release and expect A,B,C in order
    idle(1'b1, 1'b1);
    a = mkv(5'd5, 7'b1000000, 1'b0, 1'b0);
    b = mkv(5'd3, 7'b0100000, 1'b0, 1'b1);
    c = mkv(5'd31, 7'b1000000, 1'b0, 1'b0);
    send(a, 1'b0);
    send(b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, c, 1'b0, 1'b0, acc);
      check("c_refused", 32'(acc), 32'd0);
      #1;
      check("stall_valid", 32'(out_valid_u), 32'd1);
      check("stall_product", product_u, 32'd64);
    end
    send(c, 1'b1);
    drain();
    @(negedge clk);
    #1;
    check("ops_after_abc", 32'(ops_u), 32'd3);
    check("sat_after_abc", 32'(satc_u), 32'd1);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0,
            mkv(KW'($urandom_range(0, 31)), 7'($urandom), $urandom_range(0, 7) == 0,
                1'($urandom)),
            $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    drain();

    // Reset with two transactions in flight: nothing may emerge afterwards
    idle(1'b1, 1'b1);
    send(a, 1'b0);
    send(b, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid_u", 32'(out_valid_u), 32'd0);
    check("mid_rst_valid_s", 32'(out_valid_s), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready_u), 32'd1);
    check("mid_rst_ops", 32'(ops_s), 32'd0);
    q_u.delete();
    q_s.delete();
    exp_ops = 0;
    exp_sat = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, 1'b0);
      #1;
      check("post_rst_quiet", 32'(out_valid_u | out_valid_s), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/antilog_pipe.md
ANTILOG_PIPE -- requirements
Module: antilog_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, operand width; product width PW = 2*DWIDTH.
REQ-002 SHALL have parameter M_WIDTH, default 6, fractional mantissa bits (t).
REQ-003 SHALL have parameter SIGNED_EN, default 0, where 1 enables sign application to the product.
REQ-004 SHALL define KW = $clog2(DWIDTH)+1 as the characteristic-sum width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  input transaction valid.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 sum_k  input  KW  sum of operand characteristics.
REQ-010 sum_x  input  M_WIDTH+1  sum of operand fractions; MSB is carry.
REQ-011 in_zero  input  1  an operand was zero; forces product 0.
REQ-012 in_sign  input  1  product sign (XOR of operand signs); ignored when SIGNED_EN=0.
REQ-013 out_valid  output  1  output transaction valid.
REQ-014 out_ready  input  1  downstream accepts output.
REQ-015 product  output  PW  antilog result, two's complement when SIGNED_EN=1.
REQ-016 out_sat  output  1  result saturated.
REQ-017 cnt_clr  input  1  synchronous clear of both counters.
REQ-018 ops_cnt  output  16  completed output transactions, wraps at 65535->0.
REQ-019 sat_cnt  output  16  saturated output transactions, sticks at 65535.

Function
REQ-020 Stage 1 SHALL register final_k = sum_k + sum_x[M_WIDTH] (KW+1 bits, no overflow), mant = {1'b1, sum_x[M_WIDTH-1:0]}, in_zero, in_sign.
REQ-021 Stage 2 SHALL register magnitude = mant << (final_k-M_WIDTH) when final_k >= M_WIDTH, else mant >> (M_WIDTH-final_k) with shifted-out bits truncated.
REQ-022 Stage 2 SHALL set magnitude to all ones and out_sat=1 when final_k >= PW and in_zero=0.
REQ-023 in_zero=1 SHALL yield product=0, out_sat=0 regardless of sum_k, sum_x, in_sign.
REQ-024 With SIGNED_EN=1 and in_sign=1, product SHALL be the PW-bit two's-complement negation of the magnitude; saturation under sign=1 yields 1 followed by PW-1 zeros (most negative value).
REQ-025 Latency SHALL be exactly 2 cycles from accepted input to out_valid with out_ready held high; throughput 1 per cycle.
REQ-026 Handshake: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational, no in_valid dependency).
REQ-027 Transfer occurs only when valid and ready are both high; stalled stages SHALL hold data and outputs stable.
REQ-028 Transactions SHALL exit in acceptance order; no drop or duplication under any out_ready pattern.
REQ-029 ops_cnt SHALL increment on each out_valid&&out_ready; sat_cnt also when out_sat=1.
REQ-030 cnt_clr SHALL have priority over a same-cycle increment; counters read 0 next cycle.

Reset
REQ-031 rst SHALL immediately clear s1_valid, s2_valid, out_valid, out_sat, product, ops_cnt, sat_cnt to 0.
REQ-032 in_ready SHALL be 1 during and after reset; in-flight transactions at reset are discarded, not emitted.

Verification (DWIDTH=16, M_WIDTH=6)
REQ-033 sum_k=5, sum_x=7'b1000000, out_ready=1 -> 2 cycles later product=64, out_sat=0.
REQ-034 sum_k=3, sum_x=7'b0100000 -> product=12; with SIGNED_EN=1, in_sign=1 -> product=32'hFFFFFFF4.
REQ-035 sum_k=31, sum_x=7'b1000000 -> product=32'hFFFFFFFF, out_sat=1, sat_cnt=1; same with in_zero=1 -> product=0, out_sat=0.
REQ-036 out_ready=0, push A,B,C back-to-back -> A,B held, in_ready=0 on C; raise out_ready -> A,B,C emitted in order, ops_cnt=3.
REQ-037 Assert rst with two transactions in flight -> out_valid=0 immediately, counters 0, nothing emitted after release.
